status_sequencer: RTL and testbench
===================================

// Module: status_sequencer
// PURPOSE
//   Supervisory FSM producing the 2-bit status code for the simulated driver's LED decoder.
//   Sequences IDLE/RUN/WARN/FAULT from operator events and a heartbeat watchdog.
//   Enforces a minimum dwell per state so every LED state stays visible.
//   Counts fault entries. Sits between the driver's control inputs and the status-to-LED decoder.
// PARAMETERS
//   DWELL_CYCLES   4    min cycles in a state before a non-fault transition is allowed (>=1)
//   WARN_TIMEOUT   16   cycles in RUN without heartbeat before entering WARN (>=2)
//   FAULT_TIMEOUT  16   cycles in WARN without heartbeat before entering FAULT (>=2)
//   BLINK_HALF     8    blink half-period in cycles (used only with STATUS_BLINK_EN)
// PORTS
//   clk          in   1  system clock, rising edge
//   reset_n      in   1  asynchronous active-low reset
//   start_i      in   1  level, request IDLE->RUN
//   stop_i       in   1  level, request RUN/WARN->IDLE
//   heartbeat_i  in   1  level, 1-cycle pulse from driven logic; feeds watchdog
//   fault_i      in   1  level, external fault
//   clear_i      in   1  level, request FAULT->IDLE
//   status       out  2  registered state code: 0 IDLE, 1 RUN, 2 WARN, 3 FAULT
//   dwell_done   out  1  high when dwell counter has reached DWELL_CYCLES
//   fault_count  out  4  saturating count of FAULT entries
//   blink        out  1  FAULT blink (only with STATUS_BLINK_EN)
// BEHAVIOUR
//   - One clock, single async active-low reset.
//   - Reset: status=0 (IDLE), dwell counter=0, dwell_done=0, watchdog=0, fault_count=0, blink=0.
//   - All outputs registered; status changes on the edge after the triggering sample (latency 1).
//   - Dwell counter: cleared on every state change; increments each cycle; saturates at DWELL_CYCLES.
//     dwell_done = (dwell == DWELL_CYCLES).
//   - Watchdog: cleared on state change or heartbeat_i=1; increments in RUN/WARN; saturates; held 0 in IDLE/FAULT.
//   - Transition priority, evaluated every cycle:
//     1 fault_i=1 in any state except FAULT -> FAULT. Ignores dwell.
//     2 watchdog==FAULT_TIMEOUT in WARN -> FAULT. Ignores dwell.
//     3 FAULT: clear_i & dwell_done -> IDLE.
//     4 RUN/WARN: stop_i & dwell_done -> IDLE.
//     5 IDLE: start_i & dwell_done -> RUN.
//     6 WARN: heartbeat_i & dwell_done -> RUN.
//     7 RUN: watchdog==WARN_TIMEOUT -> WARN. Ignores dwell.
//     8 otherwise hold.
//   - Events blocked by dwell are dropped, not queued.
//   - fault_i=1 while already in FAULT: hold, dwell not restarted, no count.
//   - fault_i and clear_i together in FAULT: fault wins (stay).
//   - fault_count: +1 on each entry into FAULT (either cause); saturates at 15; cleared only by reset.
//   - Reset mid-operation: immediate return to reset values regardless of state or counters.
// CONFIGURATION
//   STATUS_BLINK_EN defined:
//     - blink toggles every BLINK_HALF cycles while status==3; first toggle to 1 on the FAULT entry edge.
//     - blink forced 0 and phase counter cleared in other states.
//   STATUS_BLINK_EN undefined:
//     - port blink is still present, tied to 0; no phase counter is synthesised.
// TESTING (DWELL_CYCLES=4, WARN_TIMEOUT=16, FAULT_TIMEOUT=16, BLINK_HALF=8)
//   - Release reset, start_i=1 at cycle 1 -> ignored; start_i held to cycle 5 -> status=1 one edge after dwell_done.
//   - RUN, heartbeat every 10 cycles -> status stays 1; heartbeats stop -> status=2 at 16 cycles after last heartbeat.
//   - WARN, no heartbeat -> status=3 16 cycles after WARN entry, fault_count=1. Heartbeat at WARN+5 instead -> status=1.
//   - IDLE, 1-cycle fault_i pulse at dwell=1 -> status=3 next edge; clear_i at dwell<4 ignored; clear_i at dwell=4 -> status=0.
//   - 20 fault/clear cycles -> fault_count saturates at 15. Assert reset_n=0 in RUN -> all outputs 0 immediately.
//   - With STATUS_BLINK_EN: FAULT held 32 cycles -> blink 1,0,1,0 in 8-cycle phases; exit FAULT -> blink=0.

Source files
------------

// File: rtl/status_sequencer.sv
// Supervisory IDLE/RUN/WARN/FAULT sequencer with minimum dwell, heartbeat watchdog and fault counter.
// Optional FAULT blink output is enabled by defining STATUS_BLINK_EN.
module status_sequencer #(
  parameter int DWELL_CYCLES  = 4,
  parameter int WARN_TIMEOUT  = 16,
  parameter int FAULT_TIMEOUT = 16,
  parameter int BLINK_HALF    = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       heartbeat_i,
  input  logic       fault_i,
  input  logic       clear_i,
  output logic [1:0] status,
  output logic       dwell_done,
  output logic [3:0] fault_count,
  output logic       blink
);

  localparam int DW     = $clog2(DWELL_CYCLES + 1);
  localparam int WD_MAX = (WARN_TIMEOUT > FAULT_TIMEOUT) ? WARN_TIMEOUT : FAULT_TIMEOUT;
  localparam int WW     = $clog2(WD_MAX + 1);

  localparam logic [DW-1:0] DWELL_LIM = DW'(DWELL_CYCLES);
  localparam logic [WW-1:0] WARN_LIM  = WW'(WARN_TIMEOUT);
  localparam logic [WW-1:0] FAULT_LIM = WW'(FAULT_TIMEOUT);
  localparam logic [WW-1:0] WD_SAT    = WW'(WD_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WARN  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [DW-1:0]   dwell_r;
  logic [DW-1:0]   dwell_nxt_s;
  logic            dwell_done_r;
  logic [WW-1:0]   wd_r;
  logic [WW-1:0]   wd_nxt_s;
  logic [3:0]      fault_count_r;
  logic [3:0]      fault_count_nxt_s;
  logic            changed_s;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection in priority order; dwell-gated events are simply dropped
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (fault_i) state_nxt_s = FAULT;
        else if (start_i && dwell_done_r) state_nxt_s = RUN;
        else state_nxt_s = IDLE;
      end
      RUN: begin
        if (fault_i) state_nxt_s = FAULT;
        else if (stop_i && dwell_done_r) state_nxt_s = IDLE;
        else if (wd_r == WARN_LIM) state_nxt_s = WARN;
        else state_nxt_s = RUN;
      end
      WARN: begin
        if (fault_i) state_nxt_s = FAULT;
        else if (wd_r == FAULT_LIM) state_nxt_s = FAULT;
        else if (stop_i && dwell_done_r) state_nxt_s = IDLE;
        else if (heartbeat_i && dwell_done_r) state_nxt_s = RUN;
        else state_nxt_s = WARN;
      end
      FAULT: begin
        // a fault still present blocks the clear
        if (clear_i && dwell_done_r && !fault_i) state_nxt_s = IDLE;
        else state_nxt_s = FAULT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Dwell, watchdog and fault-count next values
  always_comb begin
    changed_s         = (state_nxt_s != state_r);
    dwell_nxt_s       = dwell_r;
    wd_nxt_s          = wd_r;
    fault_count_nxt_s = fault_count_r;

    if (changed_s) dwell_nxt_s = {DW{1'b0}};
    else if (dwell_r == DWELL_LIM) dwell_nxt_s = dwell_r;
    else dwell_nxt_s = dwell_r + DW'(1);

    if (changed_s || heartbeat_i) wd_nxt_s = {WW{1'b0}};
    else if ((state_r == RUN) || (state_r == WARN)) begin
      if (wd_r == WD_SAT) wd_nxt_s = wd_r;
      else wd_nxt_s = wd_r + WW'(1);
    end else wd_nxt_s = {WW{1'b0}};

    if (changed_s && (state_nxt_s == FAULT) && (fault_count_r != 4'd15))
      fault_count_nxt_s = fault_count_r + 4'd1;
    else
      fault_count_nxt_s = fault_count_r;
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell_r       <= {DW{1'b0}};
      dwell_done_r  <= 1'b0;
      wd_r          <= {WW{1'b0}};
      fault_count_r <= 4'd0;
    end else begin
      dwell_r       <= dwell_nxt_s;
      dwell_done_r  <= (dwell_nxt_s == DWELL_LIM);
      wd_r          <= wd_nxt_s;
      fault_count_r <= fault_count_nxt_s;
    end
  end

  assign status      = state_r;
  assign dwell_done  = dwell_done_r;
  assign fault_count = fault_count_r;

`ifdef STATUS_BLINK_EN
  localparam int PW = (BLINK_HALF < 2) ? 1 : $clog2(BLINK_HALF);

  logic [PW-1:0] phase_r;
  logic          blink_r;

  // Blink phase: goes high on the FAULT entry edge, toggles every BLINK_HALF cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_r <= {PW{1'b0}};
      blink_r <= 1'b0;
    end else if (state_nxt_s != FAULT) begin
      phase_r <= {PW{1'b0}};
      blink_r <= 1'b0;
    end else if (state_r != FAULT) begin
      phase_r <= {PW{1'b0}};
      blink_r <= 1'b1;
    end else if (phase_r == PW'(BLINK_HALF - 1)) begin
      phase_r <= {PW{1'b0}};
      blink_r <= ~blink_r;
    end else begin
      phase_r <= phase_r + PW'(1);
      blink_r <= blink_r;
    end
  end

  assign blink = blink_r;
`else
  logic unused_blink_half_s;
  assign unused_blink_half_s = (BLINK_HALF > 0);
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_status_sequencer.sv
// Randomized scoreboard bench for status_sequencer; the reference model tracks entry and
// last-kick timestamps instead of counters.
module tb_status_sequencer;

  localparam int D    = 4;
  localparam int WT   = 16;
  localparam int FT   = 16;
  localparam int WMAX = (WT > FT) ? WT : FT;
`ifdef STATUS_BLINK_EN
  localparam int BH   = 8;
`endif
  localparam int N_ITER = 3000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_i, stop_i, heartbeat_i, fault_i, clear_i;
  logic [1:0] status;
  logic       dwell_done;
  logic [3:0] fault_count;
  logic       blink;

  status_sequencer #(
    .DWELL_CYCLES (D),
    .WARN_TIMEOUT (WT),
    .FAULT_TIMEOUT(FT),
    .BLINK_HALF   (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .heartbeat_i(heartbeat_i),
    .fault_i    (fault_i),
    .clear_i    (clear_i),
    .status     (status),
    .dwell_done (dwell_done),
    .fault_count(fault_count),
    .blink      (blink)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int dd;
    int fc;
    int bl;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model: state code, edge count, edge of state entry, edge of last watchdog kick
  int m_st, m_n, m_entry, m_kick, m_fc;

  task automatic check(input string name, input int cyc, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_st = 0; m_n = 0; m_entry = 0; m_kick = 0; m_fc = 0;
  endtask

  function automatic int exp_blink();
`ifdef STATUS_BLINK_EN
    if (m_st == 3) return (((m_n - m_entry) / BH) % 2 == 0) ? 1 : 0;
    return 0;
`else
    return 0;
`endif
  endfunction

  // One clock edge of the reference model with the inputs currently driven
  task automatic model_step();
    int  dw, wd, nxt;
    bit  dd;
    exp_t e;
    dw  = imin(m_n - m_entry, D);
    dd  = (dw == D);
    wd  = (m_st == 1 || m_st == 2) ? imin(m_n - m_kick, WMAX) : 0;
    nxt = m_st;
    if (fault_i && m_st != 3) nxt = 3;
    else if (m_st == 2 && wd == FT) nxt = 3;
    else if (m_st == 3 && clear_i && dd && !fault_i) nxt = 0;
    else if ((m_st == 1 || m_st == 2) && stop_i && dd) nxt = 0;
    else if (m_st == 0 && start_i && dd) nxt = 1;
    else if (m_st == 2 && heartbeat_i && dd) nxt = 1;
    else if (m_st == 1 && wd == WT) nxt = 2;
    m_n++;
    if (nxt != m_st) begin
      m_entry = m_n;
      m_kick  = m_n;
      if (nxt == 3 && m_fc < 15) m_fc++;
    end else if (heartbeat_i) begin
      m_kick = m_n;
    end
    m_st  = nxt;
    e.st  = m_st;
    e.dd  = ((m_n - m_entry) >= D) ? 1 : 0;
    e.fc  = m_fc;
    e.bl  = exp_blink();
    e.cyc = m_n;
    exp_q.push_back(e);
  endtask

  // Monitor: after every active edge, compare DUT outputs with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("status", e.cyc, int'(status), e.st);
        check("dwell_done", e.cyc, int'(dwell_done), e.dd);
        check("fault_count", e.cyc, int'(fault_count), e.fc);
        check("blink", e.cyc, int'(blink), e.bl);
      end
    end
  end

  // Stimulus driver
  initial begin
    int  mode;
    bit  reset_done;
    reset_n = 1'b0;
    start_i = 1'b0; stop_i = 1'b0; heartbeat_i = 1'b0; fault_i = 1'b0; clear_i = 1'b0;
    mode = 0;
    reset_done = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_status", 0, int'(status), 0);
    check("reset_dwell_done", 0, int'(dwell_done), 0);
    check("reset_fault_count", 0, int'(fault_count), 0);
    check("reset_blink", 0, int'(blink), 0);
    reset_n = 1'b1;

    for (int i = 0; i < N_ITER; i++) begin
      if (!reset_done && ((i >= 1500 && m_st == 1) || i == 2900)) begin
        reset_done = 1'b1;
        reset_n = 1'b0;
        #1;
        check("midrun_reset_status", m_n, int'(status), 0);
        check("midrun_reset_dwell_done", m_n, int'(dwell_done), 0);
        check("midrun_reset_fault_count", m_n, int'(fault_count), 0);
        check("midrun_reset_blink", m_n, int'(blink), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
      end

      if (i < 10) begin
        // start pulse before dwell completes is dropped; held start is taken once dwell_done
        start_i = (i == 0) || (i >= 3);
        stop_i = 1'b0; heartbeat_i = 1'b0; fault_i = 1'b0; clear_i = 1'b0;
      end else begin
        if (i % 80 == 0) mode = $urandom_range(0, 3);
        case (mode)
          0: begin
            start_i = pct(40); stop_i = pct(8); heartbeat_i = pct(15);
            fault_i = pct(2); clear_i = pct(30);
          end
          1: begin
            start_i = pct(50); stop_i = 1'b0; heartbeat_i = 1'b0;
            fault_i = 1'b0; clear_i = pct(40);
          end
          2: begin
            start_i = pct(50); stop_i = 1'b0; heartbeat_i = pct(8);
            fault_i = 1'b0; clear_i = pct(40);
          end
          default: begin
            start_i = pct(40); stop_i = pct(10); heartbeat_i = pct(20);
            fault_i = pct(15); clear_i = pct(50);
          end
        endcase
      end
      model_step();
      @(negedge clk);
    end

    start_i = 1'b0; stop_i = 1'b0; heartbeat_i = 1'b0; fault_i = 1'b0; clear_i = 1'b0;
    @(negedge clk);
    check("scoreboard_drained", m_n, exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
